// File: rtl/nx_node_pkg.sv
// Shared types and default sizes for the nx_node instruction path.
package nx_node_pkg;

    localparam int NX_INSTR_WIDTH = 15;
    localparam int NX_MAX_INSTRS  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } nx_fetch_state_t;

endpackage

// File: rtl/nx_fifo_sync.sv
// Synchronous FIFO of any depth (not restricted to powers of two) with level, empty and full flags.
module nx_fifo_sync #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == LW'(DEPTH));
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        do_push  = push_i & (~full_o | pop_i);
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/nx_node_fetch.sv
// Instruction fetch sequencer: walks store addresses 0..count-1 and streams instructions to the core.
// Optional stall/back-pressure counters are built when NX_NODE_FETCH_STATS_EN is defined.
module nx_node_fetch
    import nx_node_pkg::*;
#(
    parameter int  INSTR_WIDTH = NX_INSTR_WIDTH,
    parameter int  MAX_INSTRS  = NX_MAX_INSTRS,
    parameter int  FIFO_DEPTH  = 3,
    localparam int AW          = $clog2(MAX_INSTRS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   trigger_i,
    input  logic [AW-1:0]          instr_count_i,
    output logic [AW-1:0]          fetch_addr_o,
    output logic                   fetch_rd_o,
    input  logic [INSTR_WIDTH-1:0] fetch_data_i,
    input  logic                   fetch_stall_i,
    output logic [INSTR_WIDTH-1:0] instr_data_o,
    output logic                   instr_last_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic                   idle_o,
    output logic                   done_o
`ifdef NX_NODE_FETCH_STATS_EN
    ,
    output logic [15:0]            stat_stall_o,
    output logic [15:0]            stat_bp_o
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 3);

    nx_fetch_state_t  state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    limit_q, limit_d;
    logic             rd_q, rd_d;
    logic             inflight_q, inflight_d;
    logic             ret_last_q, ret_last_d;
    logic             done_q, done_d;

    logic             accept, room;
    logic [CW-1:0]    credit_next;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [LW-1:0]    fifo_level;
    logic [INSTR_WIDTH:0] fifo_head;

    assign accept    = rd_q & ~fetch_stall_i;
    assign fifo_pop  = ~fifo_empty & instr_ready_i;
    assign fifo_push = inflight_q & (~fifo_full | fifo_pop);

    // Entries held or in flight after this edge; a new request is only raised if one slot remains.
    assign credit_next = CW'(fifo_level) + CW'(inflight_q) + CW'(accept) - CW'(fifo_pop);
    assign room        = credit_next < CW'(FIFO_DEPTH);

    nx_fifo_sync #(
        .WIDTH (INSTR_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i ({ret_last_q, fetch_data_i}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (fifo_level)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            limit_q    <= '0;
            rd_q       <= 1'b0;
            inflight_q <= 1'b0;
            ret_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            limit_q    <= limit_d;
            rd_q       <= rd_d;
            inflight_q <= inflight_d;
            ret_last_q <= ret_last_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        limit_d    = limit_q;
        rd_d       = rd_q;
        inflight_d = 1'b0;
        ret_last_d = ret_last_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger_i) begin
                    if (instr_count_i != '0) begin
                        state_d = RUN;
                        limit_d = instr_count_i;
                        addr_d  = '0;
                        rd_d    = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    addr_d     = addr_q + AW'(1);
                    inflight_d = 1'b1;
                    ret_last_d = (addr_q == limit_q - AW'(1));
                    if (ret_last_d) begin
                        state_d = DRAIN;
                        rd_d    = 1'b0;
                    end else begin
                        rd_d    = room;
                    end
                end else if (!rd_q) begin
                    rd_d = room;
                end
            end
            DRAIN: begin
                // The last-flagged entry is the final one pushed, so popping it empties the pass.
                if (fifo_pop && fifo_head[INSTR_WIDTH]) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle_o        = (state_q == IDLE);
        fetch_rd_o    = rd_q;
        fetch_addr_o  = addr_q;
        done_o        = done_q;
        instr_valid_o = ~fifo_empty;
        instr_data_o  = fifo_empty ? '0 : fifo_head[INSTR_WIDTH-1:0];
        instr_last_o  = ~fifo_empty & fifo_head[INSTR_WIDTH];
    end

`ifdef NX_NODE_FETCH_STATS_EN
    logic [15:0] stat_stall_q, stat_stall_d;
    logic [15:0] stat_bp_q, stat_bp_d;

    always_comb begin
        stat_stall_d = stat_stall_q;
        stat_bp_d    = stat_bp_q;
        if ((state_q == IDLE) && trigger_i) begin
            stat_stall_d = '0;
            stat_bp_d    = '0;
        end else begin
            if (rd_q && fetch_stall_i && !(&stat_stall_q)) begin
                stat_stall_d = stat_stall_q + 16'd1;
            end
            if (instr_valid_o && !instr_ready_i && !(&stat_bp_q)) begin
                stat_bp_d = stat_bp_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_stall_q <= '0;
            stat_bp_q    <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_bp_q    <= stat_bp_d;
        end
    end

    assign stat_stall_o = stat_stall_q;
    assign stat_bp_o    = stat_bp_q;
`endif

endmodule

// File: tb/tb_nx_node_fetch.sv
// Directed bench for nx_node_fetch: a behavioural store model plus immediate-assertion checks.
module tb_nx_node_fetch;

    localparam int IW = 15;
    localparam int AW = 9;

    logic          clk;
    logic          rst_i;
    logic          trigger_i;
    logic [AW-1:0] instr_count_i;
    logic [AW-1:0] fetch_addr_o;
    logic          fetch_rd_o;
    logic [IW-1:0] fetch_data_i;
    logic          fetch_stall_i;
    logic [IW-1:0] instr_data_o;
    logic          instr_last_o;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic          idle_o;
    logic          done_o;
`ifdef NX_NODE_FETCH_STATS_EN
    logic [15:0]   stat_stall_o;
    logic [15:0]   stat_bp_o;
`endif

    int checks = 0;
    int errors = 0;
    int outstanding, max_out, done_cnt, acc_total;
    logic [IW-1:0] rx_data [$];
    logic          rx_last [$];

    nx_node_fetch #(
        .INSTR_WIDTH (IW),
        .MAX_INSTRS  (512),
        .FIFO_DEPTH  (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .trigger_i     (trigger_i),
        .instr_count_i (instr_count_i),
        .fetch_addr_o  (fetch_addr_o),
        .fetch_rd_o    (fetch_rd_o),
        .fetch_data_i  (fetch_data_i),
        .fetch_stall_i (fetch_stall_i),
        .instr_data_o  (instr_data_o),
        .instr_last_o  (instr_last_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .idle_o        (idle_o),
        .done_o        (done_o)
`ifdef NX_NODE_FETCH_STATS_EN
        ,
        .stat_stall_o  (stat_stall_o),
        .stat_bp_o     (stat_bp_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store contents: odd multiplier keeps every address's word distinct.
    function automatic logic [IW-1:0] model(input int a);
        return IW'((a * 149 + 677) % 32768);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_data.delete();
        rx_last.delete();
        outstanding = 0;
        max_out     = 0;
        done_cnt    = 0;
        acc_total   = 0;
    endtask

    // One clock: record this cycle's handshakes, advance, then answer the store read.
    task automatic cyc();
        logic          acc;
        logic [AW-1:0] a;
        acc = fetch_rd_o && !fetch_stall_i;
        a   = fetch_addr_o;
        if (instr_valid_o && instr_ready_i) begin
            rx_data.push_back(instr_data_o);
            rx_last.push_back(instr_last_o);
            outstanding--;
        end
        if (acc) begin
            outstanding++;
            acc_total++;
        end
        if (outstanding > max_out) max_out = outstanding;
        if (done_o) done_cnt++;
        @(posedge clk);
        #1;
        fetch_data_i = acc ? model(int'(a)) : '0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_o) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        cyc();
    endtask

    task automatic check_stream(input string tag, input int n);
        chk({tag, "_len"}, 32'(rx_data.size()), 32'(n));
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            chk({tag, "_data"}, 32'(rx_data[i]), 32'(model(i)));
            chk({tag, "_last"}, 32'(rx_last[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        int  stall_cnt;
        int  bp_left;
        logic held;
        logic found;

        rst_i         = 1'b1;
        trigger_i     = 1'b0;
        instr_count_i = '0;
        fetch_data_i  = '0;
        fetch_stall_i = 1'b0;
        instr_ready_i = 1'b1;
        clear_mon();
        cyc();
        cyc();
        rst_i = 1'b0;

        // Reset values
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_rd", 32'(fetch_rd_o), 32'd0);
        chk("rst_addr", 32'(fetch_addr_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_data", 32'(instr_data_o), 32'd0);
        chk("rst_last", 32'(instr_last_o), 32'd0);
        cyc();

        // Count 4, full-rate latency profile
        clear_mon();
        instr_count_i = 9'd4;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        chk("c4_t1_rd", 32'(fetch_rd_o), 32'd1);
        chk("c4_t1_addr", 32'(fetch_addr_o), 32'd0);
        chk("c4_t1_idle", 32'(idle_o), 32'd0);
        cyc();
        chk("c4_t2_addr", 32'(fetch_addr_o), 32'd1);
        chk("c4_t2_valid", 32'(instr_valid_o), 32'd0);
        cyc();
        chk("c4_t3_addr", 32'(fetch_addr_o), 32'd2);
        chk("c4_t3_valid", 32'(instr_valid_o), 32'd1);
        chk("c4_t3_data", 32'(instr_data_o), 32'(model(0)));
        cyc();
        chk("c4_t4_addr", 32'(fetch_addr_o), 32'd3);
        chk("c4_t4_data", 32'(instr_data_o), 32'(model(1)));
        cyc();
        chk("c4_t5_rd", 32'(fetch_rd_o), 32'd0);
        chk("c4_t5_data", 32'(instr_data_o), 32'(model(2)));
        cyc();
        chk("c4_t6_data", 32'(instr_data_o), 32'(model(3)));
        chk("c4_t6_last", 32'(instr_last_o), 32'd1);
        chk("c4_t6_done", 32'(done_o), 32'd0);
        cyc();
        chk("c4_t7_done", 32'(done_o), 32'd1);
        chk("c4_t7_idle", 32'(idle_o), 32'd1);
        chk("c4_t7_valid", 32'(instr_valid_o), 32'd0);
        cyc();
        chk("c4_t8_done", 32'(done_o), 32'd0);
        check_stream("c4", 4);
        chk("c4_done_cnt", 32'(done_cnt), 32'd1);

        // Count 0: immediate done, no reads
        clear_mon();
        instr_count_i = 9'd0;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        chk("c0_done", 32'(done_o), 32'd1);
        chk("c0_idle", 32'(idle_o), 32'd1);
        chk("c0_rd", 32'(fetch_rd_o), 32'd0);
        cyc();
        chk("c0_done_end", 32'(done_o), 32'd0);
        chk("c0_idle_end", 32'(idle_o), 32'd1);
        cyc();
        chk("c0_no_reads", 32'(acc_total), 32'd0);

        // Count 8, store stalls address 2 for three cycles
        clear_mon();
        instr_count_i = 9'd8;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        stall_cnt = 0;
        held      = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < 60; k++) begin
            fetch_stall_i = 1'b0;
            if (done_o) begin
                found = 1'b1;
                break;
            end
            if (fetch_rd_o && fetch_addr_o == 9'd2 && stall_cnt < 3) begin
                fetch_stall_i = 1'b1;
                stall_cnt++;
            end else if (stall_cnt == 3 && !held) begin
                held = 1'b1;
                chk("stall_hold_addr", 32'(fetch_addr_o), 32'd2);
                chk("stall_hold_rd", 32'(fetch_rd_o), 32'd1);
            end
            cyc();
        end
        fetch_stall_i = 1'b0;
        chk("stall_done_seen", 32'(found), 32'd1);
        chk("stall_cycles_on_addr2", 32'(stall_cnt), 32'd3);
        chk("stall_hold_seen", 32'(held), 32'd1);
        cyc();
        check_stream("stall8", 8);
        chk("stall8_done_cnt", 32'(done_cnt), 32'd1);

        // Count 6, ready low for 5 cycles from the first valid
        clear_mon();
        instr_count_i = 9'd6;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        bp_left   = -1;
        found     = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done_o) begin
                found = 1'b1;
                break;
            end
            if (bp_left < 0 && instr_valid_o) bp_left = 5;
            if (bp_left > 0) begin
                instr_ready_i = 1'b0;
                chk("bp_valid_held", 32'(instr_valid_o), 32'd1);
                chk("bp_data_stable", 32'(instr_data_o), 32'(model(0)));
                bp_left--;
            end else begin
                instr_ready_i = 1'b1;
            end
            cyc();
        end
        instr_ready_i = 1'b1;
        chk("bp_done_seen", 32'(found), 32'd1);
        cyc();
        check_stream("bp6", 6);
        chk("bp_max_outstanding", 32'(max_out), 32'd3);

        // Reset in RUN at address 3 of 10, then a fresh pass of 2
        clear_mon();
        instr_count_i = 9'd10;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (fetch_rd_o && fetch_addr_o == 9'd3) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("mrst_reached_addr3", 32'(found), 32'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("mrst_idle", 32'(idle_o), 32'd1);
        chk("mrst_valid", 32'(instr_valid_o), 32'd0);
        chk("mrst_rd", 32'(fetch_rd_o), 32'd0);
        clear_mon();
        instr_count_i = 9'd2;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        run_to_done("mrst2", 30);
        check_stream("mrst2", 2);
        chk("mrst2_done_cnt", 32'(done_cnt), 32'd1);
        chk("mrst2_reads", 32'(acc_total), 32'd2);

        // Trigger pulsed during DRAIN is ignored
        clear_mon();
        instr_count_i = 9'd3;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("drain_not_idle", 32'(idle_o), 32'd0);
        chk("drain_no_rd", 32'(fetch_rd_o), 32'd0);
        instr_count_i = 9'd5;
        trigger_i     = 1'b1;
        cyc();
        trigger_i = 1'b0;
        chk("drain_last_valid", 32'(instr_valid_o), 32'd1);
        chk("drain_last_flag", 32'(instr_last_o), 32'd1);
        cyc();
        chk("drain_done", 32'(done_o), 32'd1);
        for (int k = 0; k < 6; k++) cyc();
        chk("drain_done_cnt", 32'(done_cnt), 32'd1);
        chk("drain_reads", 32'(acc_total), 32'd3);
        chk("drain_idle_after", 32'(idle_o), 32'd1);
        check_stream("drain3", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
